// File: rtl/axis_fifo_pkg.sv
// axis_fifo_pkg: default geometry and beat layout for axis_fifo.
// Beat layout is {data, keep, last}, with data in the MSBs.
package axis_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int KEEP_WIDTH_DEF = 1;
  localparam int DEPTH_DEF      = 16;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] data;
    logic [KEEP_WIDTH_DEF-1:0] keep;
    logic                      last;
  } beat_t;

  function automatic int beat_bits(
    input int dw,
    input int kw
  );
    return dw + kw + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// axis_fifo_mem: DEPTH x WIDTH register array with one sync write port and one async read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read).
module axis_fifo_mem #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_fifo.sv
// axis_fifo: single-clock first-word-fall-through AXI4-Stream FIFO.
// Ports: aclk, aresetn, s_axis_* (upstream slave), m_axis_* (downstream master).
module axis_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int KEEP_WIDTH = KEEP_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = beat_bits(DATA_WIDTH, KEEP_WIDTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
  } fifo_beat_t;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic          rd_en;
  fifo_beat_t    wbeat;
  fifo_beat_t    rbeat;
  logic [BW-1:0] rbits;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Full drops the beat even if a read frees a slot this
  // cycle, so s_axis_tready never depends on m_axis_tready.
  assign wr_en = s_axis_tvalid && !full;
  assign rd_en = m_axis_tready && !empty;

  assign wbeat.data = s_axis_tdata;
  assign wbeat.keep = s_axis_tkeep;
  assign wbeat.last = s_axis_tlast;

  axis_fifo_mem #(
    .WIDTH (BW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (aclk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wbeat),
    .raddr (rd_ptr),
    .rdata (rbits)
  );

  assign rbeat = rbits;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign s_axis_tready = !full;
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? '0 : rbeat.data;
  assign m_axis_tkeep  = empty ? '0 : rbeat.keep;
  assign m_axis_tlast  = empty ? 1'b0 : rbeat.last;

endmodule

// File: tb/tb_axis_fifo.sv
// tb_axis_fifo: directed self-checking bench for axis_fifo.
// Covers reset, fill/overflow, drain, streaming, packets, async reset.
module tb_axis_fifo;

  logic       aclk;
  logic       aresetn;
  logic       s_axis_tvalid;
  logic [7:0] s_axis_tdata;
  logic [0:0] s_axis_tkeep;
  logic       s_axis_tlast;
  logic       s_axis_tready;
  logic       m_axis_tvalid;
  logic [7:0] m_axis_tdata;
  logic [0:0] m_axis_tkeep;
  logic       m_axis_tlast;
  logic       m_axis_tready;

  int total;
  int passed;
  int failed;

  axis_fifo #(
    .DATA_WIDTH (8),
    .KEEP_WIDTH (1),
    .DEPTH      (16)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tkeep  = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;

    // 1: reset held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_mvalid", m_axis_tvalid, 0);
      chk("rst_sready", s_axis_tready, 1);
      chk("rst_mdata", m_axis_tdata, 0);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    chk("rel_mvalid", m_axis_tvalid, 0);
    chk("rel_sready", s_axis_tready, 1);
    chk("rel_mdata", m_axis_tdata, 0);

    // 2: fill with 20 beats, 16 accepted
    m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'h10 + 8'(i);
      s_axis_tkeep  = 1'b1;
      s_axis_tlast  = 1'b0;
      tick();
      chk("fill_mvalid", m_axis_tvalid, 1);
      chk("fill_head", m_axis_tdata, 8'h10);
      chk("fill_sready", s_axis_tready, (i < 15) ? 1 : 0);
    end
    chk("fill_count", dut.count, 16);
    s_axis_tvalid = 1'b0;

    // 3: drain for 20 cycles
    m_axis_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) begin
        chk("drain_valid", m_axis_tvalid, 1);
        chk("drain_data", m_axis_tdata, 8'h10 + 8'(i));
        chk("drain_keep", m_axis_tkeep, 1);
        chk("drain_last", m_axis_tlast, 0);
      end else begin
        chk("drain_empty", m_axis_tvalid, 0);
        chk("drain_zero", m_axis_tdata, 0);
        chk("drain_zkeep", m_axis_tkeep, 0);
        chk("drain_sready", s_axis_tready, 1);
      end
      tick();
    end

    // 4: streaming from empty
    m_axis_tready = 1'b1;
    chk("strm_pre", m_axis_tvalid, 0);
    for (int i = 0; i < 10; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'h40 + 8'(i);
      s_axis_tkeep  = 1'b1;
      s_axis_tlast  = 1'b0;
      tick();
      chk("strm_valid", m_axis_tvalid, 1);
      chk("strm_data", m_axis_tdata, 8'h40 + 8'(i));
      chk("strm_count", dut.count, 1);
    end
    s_axis_tvalid = 1'b0;
    tick();
    chk("strm_end", m_axis_tvalid, 0);

    // 5: 4-beat packet, alternating keep
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'h50 + 8'(i);
      s_axis_tkeep  = (i % 2 == 0) ? 1'b1 : 1'b0;
      s_axis_tlast  = (i == 3);
      tick();
      chk("pkt_hold", m_axis_tdata, 8'h50);
      chk("pkt_hkeep", m_axis_tkeep, 1);
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pkt_data", m_axis_tdata, 8'h50 + 8'(i));
      chk("pkt_keep", m_axis_tkeep, (i % 2 == 0) ? 1 : 0);
      chk("pkt_last", m_axis_tlast, (i == 3) ? 1 : 0);
      tick();
    end
    chk("pkt_empty", m_axis_tvalid, 0);

    // 6: async reset with 5 beats held
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'h60 + 8'(i);
      s_axis_tkeep  = 1'b1;
      s_axis_tlast  = 1'b0;
      tick();
    end
    s_axis_tvalid = 1'b0;
    chk("ar_count", dut.count, 5);
    chk("ar_valid", m_axis_tvalid, 1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("ar_drop", m_axis_tvalid, 0);
    chk("ar_cnt0", dut.count, 0);
    chk("ar_sready", s_axis_tready, 1);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    chk("ar_post_v", m_axis_tvalid, 0);
    chk("ar_post_d", m_axis_tdata, 0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h77;
    tick();
    s_axis_tvalid = 1'b0;
    chk("ar_new_v", m_axis_tvalid, 1);
    chk("ar_new_d", m_axis_tdata, 8'h77);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axis_fifo.md
Name: axis_fifo

Overview:
Single-clock AXI4-Stream FIFO that buffers beats between an upstream slave port (s_axis_*) and a downstream master port (m_axis_*). Each beat carries data, a keep bit and a last flag. It decouples producer and consumer timing and drops beats offered while it is full. Output is first-word-fall-through: the head beat is presented without any read request.

Parameters:
DATA_WIDTH, 8, width of tdata in bits.
KEEP_WIDTH, 1, width of tkeep in bits.
DEPTH, 16, number of beat entries; must be a power of two and at least 2.

Ports:
aclk  input  1  rising-edge clock for all state.
aresetn  input  1  asynchronous active-low reset.
s_axis_tvalid  input  1  upstream beat valid.
s_axis_tdata  input  DATA_WIDTH  upstream data.
s_axis_tkeep  input  KEEP_WIDTH  upstream byte-keep.
s_axis_tlast  input  1  upstream end-of-packet.
s_axis_tready  output  1  equals !full; may be left unconnected.
m_axis_tvalid  output  1  head beat valid (FIFO not empty).
m_axis_tdata  output  DATA_WIDTH  head data.
m_axis_tkeep  output  KEEP_WIDTH  head keep.
m_axis_tlast  output  1  head last.
m_axis_tready  input  1  downstream accept.

Behaviour:
- One clock domain, aclk. Reset is asynchronous and active-low on aresetn.
- Reset clears wr_ptr, rd_ptr and count to 0.
  - Result: m_axis_tvalid=0, s_axis_tready=1, m_axis_tdata/tkeep/tlast=0.
  - Storage array is not reset.
  - Reset asserted mid-operation discards all content immediately.
- Internal state:
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0.
  - count, $clog2(DEPTH+1) bits.
  - full = (count==DEPTH); empty = (count==0).
- Write (wr_en = s_axis_tvalid && !full):
  - At the rising edge, {tdata,tkeep,tlast} is stored at mem[wr_ptr] and wr_ptr increments.
  - A beat offered while full is silently dropped. This holds even if a read occurs in the same cycle, so there is no combinational path from m_axis_tready to s_axis_tready.
- Read (rd_en = m_axis_tready && !empty): at the rising edge, rd_ptr increments.
- Count update:
  - wr_en only: count+1.
  - rd_en only: count-1.
  - Both in the same cycle: count unchanged.
- Output path:
  - m_axis_tvalid = !empty.
  - When not empty, m_axis_tdata/tkeep/tlast = mem[rd_ptr] (combinational read of registered storage).
  - When empty, these outputs are forced to 0.
- Latency: a beat written at edge N is visible on m_axis_* in the cycle after edge N.
- Empty boundary: a simultaneous write and read attempt while empty performs the write only.
- Ordering: strict FIFO. tkeep and tlast travel with their data, unmodified.
- Master-side AXI-Stream rule: while m_axis_tvalid=1 and m_axis_tready=0, the head beat stays stable.

Decomposition:
- Package axis_fifo_pkg:
  - default DATA_WIDTH/KEEP_WIDTH/DEPTH constants;
  - a packed beat typedef {data, keep, last} used for storage.
- One sub-module, axis_fifo_mem: a DEPTH x beat register array with one synchronous write port and one asynchronous read port.
- Pointer, count and flag logic stays in axis_fifo.

Test Plan:
1. Hold aresetn=0 for 5 cycles, then release. Required: m_axis_tvalid=0, s_axis_tready=1 and m_axis_tdata=0 throughout reset and after release.
2. DEPTH=16, m_axis_tready=0, 20 consecutive beats with tvalid=1, tkeep=1, tlast=0 and distinct data D0..D19. Required:
   - s_axis_tready falls after the 16th accepted beat;
   - count=16;
   - D16..D19 are dropped;
   - m_axis_tvalid=1 with tdata=D0 from the cycle after the first write.
3. From the full state of test 2, s_axis_tvalid=0 and m_axis_tready=1 for 20 cycles. Required:
   - D0..D15 emerge one per cycle in order, each with tkeep=1, tlast=0;
   - m_axis_tvalid=0 after the 16th beat;
   - outputs then read 0.
4. Continuous streaming with tvalid=1 and tready=1 from empty. Required:
   - each beat appears one cycle after it is written;
   - count settles at 1;
   - no data is lost.
5. Packet of 4 beats with tlast=1 on the 4th and tkeep alternating 1/0. Required: tkeep and tlast emerge aligned with their data.
6. Assert aresetn=0 while holding 5 beats. Required: m_axis_tvalid drops asynchronously, and after release the FIFO is empty.
